// File: rtl/serial_frame_tx_if.sv
// Handshake and serial-output bundle between a word source, serial_frame_tx and
// the downstream even-ones detector / checker.
interface serial_frame_tx_if #(
  parameter int unsigned WIDTH = 8
);
  logic             load_valid;
  logic [WIDTH-1:0] load_data;
  logic             load_ready;
  logic             dout;
  logic             dout_valid;
  logic             frame_start;
  logic             frame_last;
  logic             expected_even;
  logic             busy;

  modport master (
    output load_valid, load_data,
    input  load_ready, dout, dout_valid, frame_start, frame_last, expected_even, busy
  );

  modport slave (
    input  load_valid, load_data,
    output load_ready, dout, dout_valid, frame_start, frame_last, expected_even, busy
  );
endinterface

// File: rtl/serial_frame_tx.sv
// Parallel-to-serial frame transmitter: shifts WIDTH-bit words out one bit per clock
// with start/last strobes, a reference even-parity flag and optional idle gaps.
module serial_frame_tx #(
  parameter int unsigned WIDTH      = 8,
  parameter bit          MSB_FIRST  = 1'b1,
  parameter int unsigned GAP_CYCLES = 0
) (
  input  logic             clk,
  input  logic             rst,
  serial_frame_tx_if.slave io_tx
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam int unsigned GAP_W = 4;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [GAP_W-1:0] LAST_GAP = GAP_W'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_shreg;
  logic [CNT_W-1:0] r_cnt;
  logic [GAP_W-1:0] r_gap_cnt;
  logic             r_even;
  logic             r_load_ready;
  logic             r_dout;
  logic             r_dout_valid;
  logic             r_frame_start;
  logic             r_frame_last;
  logic             r_expected_even;
  logic             r_busy;

  logic             w_accept;
  logic             w_first_bit;
  logic             w_next_bit;
  logic             w_last_bit;
  logic             w_last_gap;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [GAP_W-1:0] w_gap_nxt;

  // load_ready is only ever raised where a new word may enter, so it alone gates acceptance
  assign w_accept    = io_tx.load_valid & r_load_ready;
  assign w_first_bit = MSB_FIRST ? io_tx.load_data[WIDTH-1] : io_tx.load_data[0];
  assign w_next_bit  = MSB_FIRST ? r_shreg[WIDTH-2] : r_shreg[1];
  assign w_last_bit  = (r_cnt == LAST_BIT);
  assign w_last_gap  = (r_gap_cnt == LAST_GAP);
  assign w_cnt_nxt   = r_cnt + CNT_W'(1);
  assign w_gap_nxt   = r_gap_cnt + GAP_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= S_IDLE;
      r_shreg         <= '0;
      r_cnt           <= '0;
      r_gap_cnt       <= '0;
      r_even          <= 1'b0;
      r_load_ready    <= 1'b0;
      r_dout          <= 1'b0;
      r_dout_valid    <= 1'b0;
      r_frame_start   <= 1'b0;
      r_frame_last    <= 1'b0;
      r_expected_even <= 1'b0;
      r_busy          <= 1'b0;
    end else begin
      r_load_ready    <= 1'b0;
      r_dout          <= 1'b0;
      r_dout_valid    <= 1'b0;
      r_frame_start   <= 1'b0;
      r_frame_last    <= 1'b0;
      r_expected_even <= 1'b0;
      r_busy          <= 1'b0;
      if (w_accept) begin
        r_state       <= S_SHIFT;
        r_shreg       <= io_tx.load_data;
        r_even        <= ~^io_tx.load_data;
        r_cnt         <= '0;
        r_dout        <= w_first_bit;
        r_dout_valid  <= 1'b1;
        r_frame_start <= 1'b1;
        r_busy        <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_load_ready <= 1'b1;
          end
          S_SHIFT: begin
            if (!w_last_bit) begin
              r_cnt           <= w_cnt_nxt;
              r_shreg         <= MSB_FIRST ? (r_shreg << 1) : (r_shreg >> 1);
              r_dout          <= w_next_bit;
              r_dout_valid    <= 1'b1;
              r_busy          <= 1'b1;
              r_frame_last    <= (w_cnt_nxt == LAST_BIT);
              r_expected_even <= (w_cnt_nxt == LAST_BIT) & r_even;
              r_load_ready    <= (GAP_CYCLES == 0) && (w_cnt_nxt == LAST_BIT);
            end else if (GAP_CYCLES != 0) begin
              r_state      <= S_GAP;
              r_gap_cnt    <= '0;
              r_busy       <= 1'b1;
              r_load_ready <= (GAP_CYCLES == 1);
            end else begin
              r_state      <= S_IDLE;
              r_load_ready <= 1'b1;
            end
          end
          S_GAP: begin
            if (!w_last_gap) begin
              r_gap_cnt    <= w_gap_nxt;
              r_busy       <= 1'b1;
              r_load_ready <= (w_gap_nxt == LAST_GAP);
            end else begin
              r_state      <= S_IDLE;
              r_load_ready <= 1'b1;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign io_tx.load_ready    = r_load_ready;
  assign io_tx.dout          = r_dout;
  assign io_tx.dout_valid    = r_dout_valid;
  assign io_tx.frame_start   = r_frame_start;
  assign io_tx.frame_last    = r_frame_last;
  assign io_tx.expected_even = r_expected_even;
  assign io_tx.busy          = r_busy;

endmodule
